// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
// Contents: RISC-V load/store funct3 encodings, the LSU state enum, the
// latency-counter width and a helper that expands a 4-bit byte-lane mask
// into a 32-bit bit mask.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Wide enough for MEM_LAT-1 with MEM_LAT in 1..4.
    localparam int unsigned LAT_CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    function automatic logic [31:0] byte_mask_to_bits(input logic [3:0] bmask);
        logic [31:0] bits;
        for (int i = 0; i < 4; i++) begin
            bits[8*i +: 8] = {8{bmask[i]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the byte or halfword lane out of the memory
// read word and sign- or zero-extends it; words pass through unchanged.
// Ports:
//   rd      in  32  memory read word
//   addr_lo in  2   low byte-address bits of the access
//   funct3  in  3   load funct3
//   data    out 32  aligned, extended load data
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rd[7:0];
            2'd1:    byte_sel = rd[15:8];
            2'd2:    byte_sel = rd[23:16];
            default: byte_sel = rd[31:24];
        endcase
        half_sel = addr_lo[1] ? rd[31:16] : rd[15:0];

        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = rd;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the execute stage and a word-addressed data memory.
// One request at a time: IDLE accepts, WAIT holds the memory port for MEM_LAT
// cycles (write strobe / read capture on the last one), RESP presents the
// response until it is taken. Illegal or misaligned requests skip WAIT and
// never touch the memory port.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              request handshake
//   req_we, req_funct3, req_addr,
//   req_wdata                        request payload
//   rsp_valid/rsp_ready              response handshake
//   rsp_rdata, rsp_err               response payload
//   mem_a, mem_we, mem_wd,
//   mem_write_mask, mem_rd           memory port
module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    output logic [31:0] mem_write_mask,
    input  logic [31:0] mem_rd
);

    lsu_state_e             state_q, state_d;
    logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [2:0]             f3_q, f3_d;
    logic [1:0]             addr_lo_q, addr_lo_d;
    logic [3:0]             bmask_q, bmask_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [31:0]            mem_a_q, mem_a_d;
    logic [31:0]            mem_wd_q, mem_wd_d;

    logic        f3_ok;
    logic        misaligned;
    logic        req_legal;
    logic [31:0] req_wd;
    logic [3:0]  req_bmask;
    logic [31:0] load_data;
    logic        cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    // Request classification and store lane placement.
    always_comb begin
        case (req_funct3)
            F3_B, F3_H, F3_W: f3_ok = 1'b1;
            F3_BU, F3_HU:     f3_ok = !req_we;
            default:          f3_ok = 1'b0;
        endcase
        misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_legal  = f3_ok && !misaligned;

        case (req_funct3[1:0])
            2'b00: begin
                req_wd    = {4{req_wdata[7:0]}};
                req_bmask = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                req_wd    = {2{req_wdata[15:0]}};
                req_bmask = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                req_wd    = req_wdata;
                req_bmask = 4'b1111;
            end
        endcase
    end

    lsu_load_align u_load_align (
        .rd      (mem_rd),
        .addr_lo (addr_lo_q),
        .funct3  (f3_q),
        .data    (load_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req_valid) state_d = req_legal ? WAIT : RESP;
            WAIT: if (cnt_zero)  state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state.
    always_comb begin
        cnt_d     = cnt_q;
        we_d      = we_q;
        f3_d      = f3_q;
        addr_lo_d = addr_lo_q;
        bmask_d   = bmask_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        mem_a_d   = mem_a_q;
        mem_wd_d  = mem_wd_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    f3_d      = req_funct3;
                    addr_lo_d = req_addr[1:0];
                    rdata_d   = '0;
                    err_d     = !req_legal;
                    // Error requests leave the memory port untouched.
                    if (req_legal) begin
                        cnt_d    = LAT_CNT_W'(MEM_LAT - 1);
                        mem_a_d  = {req_addr[31:2], 2'b00};
                        mem_wd_d = req_wd;
                        bmask_d  = req_we ? req_bmask : 4'b0000;
                    end
                end
            end
            WAIT: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end else if (!we_q) begin
                    rdata_d = load_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            we_q      <= 1'b0;
            f3_q      <= '0;
            addr_lo_q <= '0;
            bmask_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            mem_a_q   <= '0;
            mem_wd_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            f3_q      <= f3_d;
            addr_lo_q <= addr_lo_d;
            bmask_q   <= bmask_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            mem_a_q   <= mem_a_d;
            mem_wd_q  <= mem_wd_d;
        end
    end

    // Outputs decoded from the state register, so reset kills mem_we at once.
    always_comb begin
        req_ready      = (state_q == IDLE);
        rsp_valid      = (state_q == RESP);
        mem_we         = (state_q == WAIT) && we_q && cnt_zero;
        mem_write_mask = (state_q == WAIT) ? byte_mask_to_bits(bmask_q) : 32'd0;
        mem_a          = mem_a_q;
        mem_wd         = mem_wd_q;
        rsp_rdata      = rdata_q;
        rsp_err        = err_q;
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed cases with literal expectations, then random
// traffic checked every cycle against a transaction-level reference model.
module tb_dmem_lsu;

    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_write_mask;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    dmem_lsu #(.MEM_LAT(LAT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .mem_a          (mem_a),
        .mem_we         (mem_we),
        .mem_wd         (mem_wd),
        .mem_write_mask (mem_write_mask),
        .mem_rd         (mem_rd)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (32'h1357_9BDF * (i + 1)) ^ 32'hA5A5_0000;
    endfunction

    // Simple 16-word memory behind the port.
    logic [31:0] dmem [16];
    logic        mem_init = 1'b1;
    int          we_count = 0;
    logic [31:0] last_a, last_wd, last_mask;

    assign mem_rd = dmem[mem_a[5:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) dmem[i] <= init_word(i);
        end else if (mem_we) begin
            dmem[mem_a[5:2]] <= (dmem[mem_a[5:2]] & ~mem_write_mask) | (mem_wd & mem_write_mask);
            we_count  <= we_count + 1;
            last_a    <= mem_a;
            last_wd   <= mem_wd;
            last_mask <= mem_write_mask;
        end
    end

    // ---------------- reference model helpers ----------------
    function automatic int access_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit is_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        bit f3_ok;
        if (we) f3_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    f3_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        return f3_ok && ((int'(addr[1:0]) % access_bytes(f3)) == 0);
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] f3);
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: begin
                v = (w >> (8 * int'(a))) & 32'hFF;
                if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
                if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    logic [31:0] ref_mem [16];
    bit          m_busy = 0;
    bit          m_err, m_store;
    int          m_wait_end, m_rsp_start, m_first, m_nbytes, m_idx;
    logic [31:0] m_rdata, m_mask, m_wd, m_wdata, m_mem_a;
    int          now = 0;

    initial begin
        forever begin
            @(negedge clk);
            now++;
            if (mem_init) for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
            if (!rst_n) begin
                m_busy  = 0;
                m_mem_a = 32'd0;
                check("reset req_ready", {31'd0, req_ready}, 32'd1);
                check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
                check("reset rsp_rdata", rsp_rdata, 32'd0);
                check("reset rsp_err", {31'd0, rsp_err}, 32'd0);
                check("reset mem_a", mem_a, 32'd0);
                check("reset mem_we", {31'd0, mem_we}, 32'd0);
                check("reset mem_wd", mem_wd, 32'd0);
                check("reset mem_write_mask", mem_write_mask, 32'd0);
            end else begin
                bit in_wait, exp_valid, exp_we;
                exp_valid = m_busy && (now >= m_rsp_start);
                in_wait   = m_busy && !m_err && !exp_valid;
                exp_we    = in_wait && m_store && (now == m_wait_end);
                check("req_ready", {31'd0, req_ready}, {31'd0, !m_busy});
                check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
                check("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
                check("mem_write_mask", mem_write_mask, (in_wait && m_store) ? m_mask : 32'd0);
                check("mem_a", mem_a, m_mem_a);
                if (in_wait && m_store) check("mem_wd", mem_wd, m_wd);
                if (exp_valid) begin
                    check("rsp_rdata", rsp_rdata, m_rdata);
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
                end
                // Advance the model with the inputs the next edge will see.
                if (exp_we) begin
                    for (int b = m_first; b < m_first + m_nbytes; b++)
                        ref_mem[m_idx][8*b +: 8] = m_wdata[8*(b - m_first) +: 8];
                end
                if (exp_valid && rsp_ready) begin
                    m_busy = 0;
                end else if (!m_busy && req_valid) begin
                    m_busy      = 1;
                    m_store     = req_we;
                    m_err       = !is_legal(req_we, req_funct3, req_addr);
                    m_nbytes    = access_bytes(req_funct3);
                    m_first     = int'(req_addr[1:0]) - (int'(req_addr[1:0]) % m_nbytes);
                    m_idx       = int'(req_addr[5:2]);
                    m_wdata     = req_wdata;
                    m_wait_end  = now + LAT;
                    m_rsp_start = m_err ? now + 1 : now + LAT + 1;
                    m_rdata     = 32'd0;
                    if (!m_err) begin
                        m_mem_a = {req_addr[31:2], 2'b00};
                        m_mask  = 32'd0;
                        for (int b = m_first; b < m_first + m_nbytes; b++)
                            m_mask[8*b +: 8] = 8'hFF;
                        for (int i = 0; i < 4; i++)
                            m_wd[8*i +: 8] = req_wdata[8*(i % m_nbytes) +: 8];
                        if (!req_we)
                            m_rdata = load_ext(ref_mem[m_idx], req_addr[1:0], req_funct3);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold, input bit pulse,
                        output logic [31:0] rdata, output logic err, output int lat);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) check("req_ready wait", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        rsp_ready  = (hold == 0);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!rsp_valid) check("rsp_valid wait", {31'd0, rsp_valid}, 32'd1);
        rdata = rsp_rdata;
        err   = rsp_err;
        for (int i = 0; i < hold; i++) begin
            req_valid = pulse && (i == 1);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, wc;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;

        repeat (3) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        mem_init = 1'b0;
        @(posedge clk); #1;

        // SW 0x100 <- DEADBEEF
        wc = we_count;
        send(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, rd, er, lat);
        check("sw write count", we_count - wc, 32'd1);
        check("sw mem_a", last_a, 32'h100);
        check("sw mask", last_mask, 32'hFFFF_FFFF);
        check("sw wd", last_wd, 32'hDEAD_BEEF);
        check("sw latency", lat, LAT + 1);
        check("sw err", {31'd0, er}, 32'd0);
        check("sw rdata", rd, 32'd0);

        // SB 0x103 <- AB
        send(1'b1, 3'b000, 32'h103, 32'h0000_00AB, 1, 0, rd, er, lat);
        check("sb mem_a", last_a, 32'h100);
        check("sb mask", last_mask, 32'hFF00_0000);
        check("sb wd", last_wd, 32'hABAB_ABAB);

        // Loads from 0x12F45678
        send(1'b1, 3'b010, 32'h100, 32'h12F4_5678, 0, 0, rd, er, lat);
        wc = we_count;
        send(1'b0, 3'b000, 32'h102, 32'h0, 0, 0, rd, er, lat);
        check("lb rdata", rd, 32'hFFFF_FFF4);
        check("lb latency", lat, LAT + 1);
        send(1'b0, 3'b100, 32'h102, 32'h0, 2, 0, rd, er, lat);
        check("lbu rdata", rd, 32'h0000_00F4);
        send(1'b0, 3'b101, 32'h102, 32'h0, 0, 0, rd, er, lat);
        check("lhu rdata", rd, 32'h0000_12F4);
        check("load write count", we_count - wc, 32'd0);

        // Misaligned accesses
        send(1'b0, 3'b001, 32'h101, 32'h0, 0, 0, rd, er, lat);
        check("lh mis err", {31'd0, er}, 32'd1);
        check("lh mis rdata", rd, 32'd0);
        check("lh mis latency", lat, 32'd1);
        send(1'b0, 3'b010, 32'h102, 32'h0, 1, 0, rd, er, lat);
        check("lw mis err", {31'd0, er}, 32'd1);
        check("lw mis rdata", rd, 32'd0);
        check("lw mis latency", lat, 32'd1);
        check("mis write count", we_count - wc, 32'd0);

        // Held response with an ignored request pulse
        send(1'b0, 3'b010, 32'h100, 32'h0, 5, 1, rd, er, lat);
        check("lw held rdata", rd, 32'h12F4_5678);
        check("req_ready after rsp", {31'd0, req_ready}, 32'd1);

        // Reset during WAIT cycle 2 of a store
        wc = we_count;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h120; req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async mem_we", {31'd0, mem_we}, 32'd0);
        check("async mask", mem_write_mask, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post-reset req_ready", {31'd0, req_ready}, 32'd1);
        check("aborted write count", we_count - wc, 32'd0);
        send(1'b0, 3'b010, 32'h120, 32'h0, 0, 0, rd, er, lat);
        check("aborted word intact", rd, init_word(8));

        // Random traffic; the per-cycle compare does the checking.
        for (int t = 0; t < 300; t++) begin
            int sz;
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                f3 = 3'($urandom_range(0, 7));
            end else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            addr = $urandom;
            sz = access_bytes(f3);
            if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(sz) - 32'd1);
            send(we, f3, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                 rd, er, lat);
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
